// File: rtl/spi_master_ctrl.sv
// SPI master: one full-duplex MSB-first transfer per accepted command; optional SPI_MASTER_LOOPBACK_EN adds lpbk.
// Latency: accept-to-done 1 + CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD clk cycles, all outputs registered.
// Backpressure: tx_ready only in IDLE; tx_valid while a transfer is in flight is dropped, not queued.
module spi_master_ctrl #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              sck,
    output logic              csn,
    output logic              si,
    input  logic              so
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic              lpbk
`endif
);

    localparam int M1     = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int M2     = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int PH_MAX = (M1 > M2) ? M1 : M2;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    localparam logic [PH_W-1:0]  SETUP_LD = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  DIV_LD   = PH_W'(CLK_DIV - 1);
    // The trailing low half-period after the last fall is folded into the hold window.
    localparam logic [PH_W-1:0]  HOLD_LD  = PH_W'(CLK_DIV + CS_HOLD - 1);
    localparam logic [PH_W-1:0]  GAP_LD   = PH_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    state_t            state;
    logic [PH_W-1:0]   ph;
    logic [BIT_W-1:0]  bit_k;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lpbk_q;
    assign rx_bit = lpbk_q ? si : so;
`else
    assign rx_bit = so;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= '0;
            bit_k    <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            sck      <= 1'b0;
            csn      <= 1'b1;
            si       <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lpbk_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr    <= tx_data;
                        si       <= tx_data[DATA_W-1];
                        csn      <= 1'b0;
                        bit_k    <= '0;
                        ph       <= SETUP_LD;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
                        lpbk_q   <= lpbk;
`endif
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT_LO: begin
                    if (ph == '0) begin
                        sck   <= 1'b1;
                        si    <= tx_sr[DATA_W-1];
                        ph    <= DIV_LD;
                        state <= SHIFT_HI;
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (ph == '0) begin
                        // Falling edge: slave captures si now, so has been stable for a half-period.
                        sck   <= 1'b0;
                        rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        if (bit_k == LAST_BIT) begin
                            ph    <= HOLD_LD;
                            state <= HOLD;
                        end else begin
                            bit_k <= bit_k + 1'b1;
                            ph    <= DIV_LD;
                            state <= SHIFT_LO;
                        end
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                HOLD: begin
                    if (ph == '0) begin
                        csn     <= 1'b1;
                        rx_data <= rx_sr;
                        done    <= 1'b1;
                        ph      <= GAP_LD;
                        state   <= GAP;
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                GAP: begin
                    if (ph == '0) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        ph <= ph - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default 32-bit instance plus an 8-bit, CLK_DIV=3 instance for edge timing.
module tb_spi_master_ctrl;

    localparam int SET = 2, HLD = 2, IDL = 2;
    localparam int DW_A = 32, DIV_A = 4;
    localparam int DW_B = 8,  DIV_B = 3;
    localparam int LAT_A = 1 + SET + (2 * DW_A - 1) * DIV_A + HLD + DIV_A;
    localparam int LAT_B = 1 + SET + (2 * DW_B - 1) * DIV_B + HLD + DIV_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A (defaults) ----------------
    logic        rst_a = 1'b1, tx_valid_a = 1'b0;
    logic [31:0] tx_data_a = '0;
    logic        tx_ready_a, done_a, busy_a, sck_a, csn_a, si_a, so_a;
    logic [31:0] rx_data_a;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic lpbk_a = 1'b0, lpbk_b = 1'b0, so_zero_a = 1'b0;
`endif

    spi_master_ctrl u_a (
        .clk(clk), .rst(rst_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .tx_data(tx_data_a), .rx_data(rx_data_a), .done(done_a), .busy(busy_a),
        .sck(sck_a), .csn(csn_a), .si(si_a), .so(so_a)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .lpbk(lpbk_a)
`endif
    );

    // Slave shift register: reloads on csn fall, drives MSB on sck rise, captures si on sck fall.
    logic [31:0] sl_a = '0, sl_init_a = '0;
    logic        so_qa = 1'b0, sck_pa = 1'b0, csn_pa = 1'b1;
    always @(sck_a or csn_a) begin
        if (csn_pa && !csn_a) sl_a = sl_init_a;
        if (!sck_pa && sck_a) so_qa = sl_a[31];
        if (sck_pa && !sck_a) sl_a = {sl_a[30:0], si_a};
        sck_pa = sck_a;
        csn_pa = csn_a;
    end
`ifdef SPI_MASTER_LOOPBACK_EN
    assign so_a = so_zero_a ? 1'b0 : so_qa;
`else
    assign so_a = so_qa;
`endif

    int rises_a = 0, falls_a = 0, csn_rises_a = 0, csn_falls_a = 0, done_cnt_a = 0;
    int run_a = 0, last_gap_a = 0;
    always @(posedge sck_a) rises_a++;
    always @(negedge sck_a) falls_a++;
    always @(posedge csn_a) csn_rises_a++;
    always @(negedge csn_a) csn_falls_a++;
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (csn_a) run_a++;
        else begin
            if (run_a != 0) last_gap_a = run_a;
            run_a = 0;
        end
    end

    // ---------------- instance B (8 bits, CLK_DIV=3) ----------------
    logic       rst_b = 1'b1, tx_valid_b = 1'b0;
    logic [7:0] tx_data_b = '0;
    logic       tx_ready_b, done_b, busy_b, sck_b, csn_b, si_b, so_b;
    logic [7:0] rx_data_b;

    spi_master_ctrl #(.DATA_W(DW_B), .CLK_DIV(DIV_B), .CS_SETUP(SET), .CS_HOLD(HLD), .CS_IDLE(IDL)) u_b (
        .clk(clk), .rst(rst_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .tx_data(tx_data_b), .rx_data(rx_data_b), .done(done_b), .busy(busy_b),
        .sck(sck_b), .csn(csn_b), .si(si_b), .so(so_b)
`ifdef SPI_MASTER_LOOPBACK_EN
        , .lpbk(lpbk_b)
`endif
    );

    logic [7:0] sl_b = '0, sl_init_b = '0;
    logic       so_qb = 1'b0, sck_pb = 1'b0, csn_pb = 1'b1;
    always @(sck_b or csn_b) begin
        if (csn_pb && !csn_b) sl_b = sl_init_b;
        if (!sck_pb && sck_b) so_qb = sl_b[7];
        if (sck_pb && !sck_b) sl_b = {sl_b[6:0], si_b};
        sck_pb = sck_b;
        csn_pb = csn_b;
    end
    assign so_b = so_qb;

    int rises_b = 0, falls_b = 0, tviol_b = 0;
    int hi_run_b = 0, lo_run_b = 0;
    bit seen_rise_b = 1'b0;
    logic sck_sb = 1'b0, si_sb = 1'b0, csn_sb = 1'b1;
    always @(posedge sck_b) rises_b++;
    always @(negedge sck_b) falls_b++;
    // Mid-cycle phase-length and si-stability watcher.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (!csn_b) begin
                if (sck_b && !sck_sb) begin
                    if (seen_rise_b && lo_run_b != DIV_B) tviol_b++;
                    seen_rise_b = 1'b1;
                    hi_run_b = 1;
                end else if (!sck_b && sck_sb) begin
                    if (hi_run_b != DIV_B) tviol_b++;
                    lo_run_b = 1;
                end else if (sck_b) hi_run_b++;
                else lo_run_b++;
            end else seen_rise_b = 1'b0;
            if (si_b !== si_sb && !(sck_b && !sck_sb) && !(!csn_b && csn_sb)) tviol_b++;
        end
        sck_sb = sck_b;
        si_sb  = si_b;
        csn_sb = csn_b;
    end

    // ---------------- helpers ----------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer_a(input string tag, input logic [31:0] d, input logic [31:0] slv,
                          input logic [31:0] exp_rx, input bit poke);
        int n, r0, f0, c0, w;
        logic rdy_seen;
        sl_init_a  = slv;
        tx_valid_a = 1'b1;
        tx_data_a  = d;
        w = 0;
        while (!tx_ready_a && w < 100) begin tick(); w++; end
        chk1({tag, "/ready"}, tx_ready_a, 1'b1);
        r0 = rises_a; f0 = falls_a; c0 = csn_rises_a;
        tick();
        tx_valid_a = 1'b0;
        chk1({tag, "/busy"}, busy_a, 1'b1);
        n = 1;
        rdy_seen = 1'b0;
        while (!done_a && n < 2 * LAT_A) begin
            if (poke && n == 50) begin tx_valid_a = 1'b1; tx_data_a = 32'hFFFF_FFFF; end
            if (poke && n == 60) tx_valid_a = 1'b0;
            rdy_seen |= tx_ready_a;
            tick();
            n++;
        end
        chk32({tag, "/latency"}, n, LAT_A);
        chk32({tag, "/rx"}, rx_data_a, exp_rx);
        chk32({tag, "/sck_rises"}, rises_a - r0, DW_A);
        chk32({tag, "/sck_falls"}, falls_a - f0, DW_A);
        chk32({tag, "/csn_rises"}, csn_rises_a - c0, 1);
        chk32({tag, "/slave"}, sl_a, d);
        chk1({tag, "/no_ready"}, rdy_seen, 1'b0);
        tick();
        chk1({tag, "/done_pulse"}, done_a, 1'b0);
        chk32({tag, "/rx_hold"}, rx_data_a, exp_rx);
    endtask

    task automatic xfer_b(input string tag, input logic [7:0] d, input logic [7:0] slv);
        int n, r0, f0, v0, w;
        sl_init_b  = slv;
        tx_valid_b = 1'b1;
        tx_data_b  = d;
        w = 0;
        while (!tx_ready_b && w < 100) begin tick(); w++; end
        r0 = rises_b; f0 = falls_b; v0 = tviol_b;
        tick();
        tx_valid_b = 1'b0;
        n = 1;
        while (!done_b && n < 2 * LAT_B) begin tick(); n++; end
        chk32({tag, "/latency"}, n, LAT_B);
        chk32({tag, "/rx"}, {24'b0, rx_data_b}, {24'b0, slv});
        chk32({tag, "/slave"}, {24'b0, sl_b}, {24'b0, d});
        chk32({tag, "/sck_rises"}, rises_b - r0, DW_B);
        chk32({tag, "/sck_falls"}, falls_b - f0, DW_B);
        chk32({tag, "/timing"}, tviol_b - v0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, rs;
        int c0, d0, w, r0;

        // Reset state
        repeat (3) tick();
        chk1("rst/tx_ready", tx_ready_a, 1'b1);
        chk1("rst/busy", busy_a, 1'b0);
        chk1("rst/done", done_a, 1'b0);
        chk1("rst/sck", sck_a, 1'b0);
        chk1("rst/csn", csn_a, 1'b1);
        chk1("rst/si", si_a, 1'b0);
        chk32("rst/rx", rx_data_a, 32'h0);
        chk1("rst/csn_b", csn_b, 1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) tick();

        // Basic transfer, then back-to-back with tx_valid held high
        xfer_a("t1", 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        xfer_a("t2", 32'hA5A5_A5A5, 32'h1234_5678, 32'h1234_5678, 1'b0);
        chk32("t2/csn_gap", last_gap_a, IDL + 1);

        // Command while busy is dropped
        rs = $urandom;
        xfer_a("t4", 32'h0F1E_2D3C, rs, rs, 1'b1);
        c0 = csn_falls_a;
        repeat (20) tick();
        chk32("t4/no_second", csn_falls_a - c0, 0);
        chk1("t4/ready_idle", tx_ready_a, 1'b1);

        for (int i = 0; i < 3; i++) begin
            rd = $urandom;
            rs = $urandom;
            xfer_a("rand_a", rd, rs, rs, 1'b0);
        end

        // Reset during bit 10
        sl_init_a  = $urandom;
        tx_valid_a = 1'b1;
        tx_data_a  = $urandom;
        w = 0;
        while (!tx_ready_a && w < 100) begin tick(); w++; end
        r0 = rises_a;
        tick();
        tx_valid_a = 1'b0;
        w = 0;
        while (rises_a - r0 < 11 && w < 2 * LAT_A) begin tick(); w++; end
        chk32("t3/at_bit10", rises_a - r0, 11);
        rst_a = 1'b1;
        d0 = done_cnt_a;
        tick();
        chk1("t3/csn", csn_a, 1'b1);
        chk1("t3/sck", sck_a, 1'b0);
        chk1("t3/busy", busy_a, 1'b0);
        chk1("t3/done", done_a, 1'b0);
        chk1("t3/tx_ready", tx_ready_a, 1'b1);
        rst_a = 1'b0;
        repeat (LAT_A + 20) tick();
        chk32("t3/no_done", done_cnt_a - d0, 0);
        chk32("t3/rx", rx_data_a, 32'h0);

`ifdef SPI_MASTER_LOOPBACK_EN
        so_zero_a = 1'b1;
        lpbk_a    = 1'b1;
        xfer_a("t6/lpbk", 32'hC3C3_C3C3, 32'h9999_9999, 32'hC3C3_C3C3, 1'b0);
        lpbk_a    = 1'b0;
        xfer_a("t6/so_zero", 32'hC3C3_C3C3, 32'h9999_9999, 32'h0, 1'b0);
        so_zero_a = 1'b0;
`endif

        // Edge timing on the 8-bit instance
        xfer_b("t5", 8'h5A, 8'hC6);
        for (int i = 0; i < 2; i++) begin
            rd = $urandom;
            rs = $urandom;
            xfer_b("rand_b", rd[7:0], rs[7:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
